// File: rtl/msk_unmask_deserializer.sv
// Recombines d-share masked columns into cleartext and assembles NCOL columns
// into one output block, with valid/ready handshakes on both sides.
module msk_unmask_deserializer #(
    parameter int d    = 2,
    parameter int W    = 32,
    parameter int NCOL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [d*W-1:0]      in_sh,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W*NCOL-1:0]   out_data
);

    localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NCOL - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W*NCOL-1:0]     data_q, data_d;
    logic                  accept;
    logic                  wr_en;
    logic [CW-1:0]         wr_idx;
    logic [W-1:0]          col_plain;

    // Share j of bit i sits at in_sh[i*d+j]; XOR across shares recovers bit i.
    function automatic logic [W-1:0] unmask(input logic [d*W-1:0] sh);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < d; j++) begin
                r[i] = r[i] ^ sh[i*d + j];
            end
        end
        return r;
    endfunction

    assign col_plain = unmask(in_sh);

    always_comb begin
        in_ready = (state_q == COLLECT) ? 1'b1 : out_ready;
        accept   = in_valid && in_ready && !clear;
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en    = 1'b0;
        wr_idx   = cnt_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = cnt_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d = FULL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (accept) begin
                        // Drain and refill in the same cycle: new column opens the next block.
                        wr_en  = 1'b1;
                        wr_idx = '0;
                        if (NCOL == 1) begin
                            state_d = FULL;
                            cnt_d   = '0;
                        end else begin
                            state_d = COLLECT;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase

        if (clear) begin
            state_d = COLLECT;
            cnt_d   = '0;
        end
    end

    always_comb begin
        data_d = data_q;
        for (int k = 0; k < NCOL; k++) begin
            if (wr_en && (wr_idx == CW'(k))) begin
                data_d[k*W +: W] = col_plain;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

endmodule

// File: tb/tb_msk_unmask_deserializer.sv
// Scoreboard bench: a d=2 instance for directed tests and a d=3 instance
// for the random-mask stream, both checked against a cycle model.
module tb_msk_unmask_deserializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         clear2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic         in_ready2, out_valid2;
    logic [63:0]  in_sh2 = '0;
    logic [127:0] out_data2;
    logic [31:0]  c2_cur = '0;

    logic         clear3 = 1'b0, in_valid3 = 1'b0, out_ready3 = 1'b1;
    logic         in_ready3, out_valid3;
    logic [95:0]  in_sh3 = '0;
    logic [127:0] out_data3;
    logic [31:0]  c3_cur = '0;

    msk_unmask_deserializer #(.d(2), .W(32), .NCOL(4)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_sh(in_sh2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
    );

    msk_unmask_deserializer #(.d(3), .W(32), .NCOL(4)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_sh(in_sh3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask2(input logic [31:0] c, input logic [31:0] r);
        logic [63:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i*2]     = r[i];
            m[i*2 + 1] = c[i] ^ r[i];
        end
        return m;
    endfunction

    function automatic logic [95:0] mask3(input logic [31:0] c, input logic [31:0] r1,
                                          input logic [31:0] r2);
        logic [95:0] m;
        for (int i = 0; i < 32; i++) begin
            m[i*3]     = r1[i];
            m[i*3 + 1] = r2[i];
            m[i*3 + 2] = c[i] ^ r1[i] ^ r2[i];
        end
        return m;
    endfunction

    // Reference model state, one slot per instance (0 = u2, 1 = u3)
    logic         m_full [2];
    int           m_cnt  [2];
    logic [31:0]  mcol   [2][4];
    int           acc_n  [2];
    int           pulse_n[2];
    logic [127:0] q0[$];
    logic [127:0] q1[$];

    task automatic model_step(input int k, input logic iv, input logic ir, input logic clr,
                              input logic ordy, input logic ov, input logic [127:0] od,
                              input logic [31:0] c);
        logic         exp_ir;
        logic [127:0] front;
        logic [127:0] blk;
        exp_ir = !m_full[k] || ordy;
        chk(k != 0 ? "u3 in_ready" : "u2 in_ready", ir, exp_ir);
        chk(k != 0 ? "u3 out_valid" : "u2 out_valid", ov, m_full[k]);
        if (m_full[k]) begin
            front = (k != 0) ? q1[0] : q0[0];
            chk(k != 0 ? "u3 out_data" : "u2 out_data", od, front);
            pulse_n[k]++;
        end
        if (clr) begin
            m_full[k] = 1'b0;
            m_cnt[k]  = 0;
            if (k != 0) q1.delete(); else q0.delete();
        end else begin
            if (m_full[k] && ordy) begin
                m_full[k] = 1'b0;
                if (k != 0) void'(q1.pop_front()); else void'(q0.pop_front());
            end
            if (iv && exp_ir) begin
                mcol[k][m_cnt[k]] = c;
                m_cnt[k]++;
                acc_n[k]++;
                if (m_cnt[k] == 4) begin
                    blk = {mcol[k][3], mcol[k][2], mcol[k][1], mcol[k][0]};
                    if (k != 0) q1.push_back(blk); else q0.push_back(blk);
                    m_full[k] = 1'b1;
                    m_cnt[k]  = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_full[k] = 1'b0;
                m_cnt[k]  = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            model_step(0, in_valid2, in_ready2, clear2, out_ready2, out_valid2, out_data2, c2_cur);
            model_step(1, in_valid3, in_ready3, clear3, out_ready3, out_valid3, out_data3, c3_cur);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set2(input logic [31:0] c);
        c2_cur    = c;
        in_sh2    = mask2(c, $urandom);
        in_valid2 = 1'b1;
    endtask

    // Presents a column and holds it until accepted; in_valid stays high afterwards.
    task automatic send2(input logic [31:0] c);
        logic took;
        took = 1'b0;
        set2(c);
        for (int t = 0; t < 50 && !took; t++) begin
            @(negedge clk);
            took = in_ready2 && !clear2;
            @(posedge clk);
            #1;
        end
        chk("u2 accept", took, 1'b1);
    endtask

    logic [31:0] cv [4];
    logic [127:0] held;

    initial begin
        #1_000_000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int guard;
        logic took;

        @(posedge clk);
        #1;
        chk("reset out_valid", out_valid2, 1'b0);
        chk("reset out_data", out_data2, 128'h0);
        chk("reset in_ready", in_ready2, 1'b1);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // Single block, d=2
        out_ready2 = 1'b1;
        send2(32'h00112233);
        send2(32'h44556677);
        send2(32'h8899AABB);
        send2(32'hCCDDEEFF);
        chk("t1 out_valid", out_valid2, 1'b1);
        chk("t1 out_data", out_data2, 128'hCCDDEEFF_8899AABB_44556677_00112233);
        in_valid2 = 1'b0;
        cyc(2);

        // Backpressure with a pending column
        out_ready2 = 1'b0;
        for (int i = 0; i < 4; i++) send2($urandom);
        held = out_data2;
        set2(32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp in_ready", in_ready2, 1'b0);
            chk("bp out_data", out_data2, held);
            @(posedge clk);
            #1;
        end
        out_ready2 = 1'b1;
        cyc(1);
        chk("bp drained", out_valid2, 1'b0);
        for (int i = 0; i < 3; i++) send2($urandom);
        chk("bp slot0", out_data2[31:0], 32'hDEADBEEF);
        in_valid2 = 1'b0;
        cyc(2);

        // Back-to-back blocks, no bubbles
        acc_n[0]   = 0;
        pulse_n[0] = 0;
        for (int i = 0; i < 12; i++) begin
            set2($urandom);
            cyc(1);
        end
        in_valid2 = 1'b0;
        cyc(1);
        chk("b2b accepts", acc_n[0], 12);
        chk("b2b pulses", pulse_n[0], 3);
        cyc(1);

        // Clear mid-block
        send2(32'h11111111);
        send2(32'h22222222);
        clear2 = 1'b1;
        set2(32'h33333333);
        cyc(1);
        clear2 = 1'b0;
        cv[0] = 32'hA5A5A5A5; cv[1] = 32'h5A5A5A5A; cv[2] = 32'h0F0F0F0F; cv[3] = 32'hF0F0F0F0;
        for (int i = 0; i < 4; i++) send2(cv[i]);
        chk("clr out_valid", out_valid2, 1'b1);
        chk("clr out_data", out_data2, {cv[3], cv[2], cv[1], cv[0]});
        in_valid2 = 1'b0;
        cyc(2);

        // Asynchronous reset while FULL
        out_ready2 = 1'b0;
        for (int i = 0; i < 4; i++) send2($urandom | 32'h1);
        in_valid2 = 1'b0;
        chk("ar full", out_valid2, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid", out_valid2, 1'b0);
        chk("ar out_data", out_data2, 128'h0);
        chk("ar in_ready", in_ready2, 1'b1);
        #4;
        rst_n = 1'b1;
        out_ready2 = 1'b1;
        cyc(2);

        // Random masks, d=3
        n = 0;
        guard = 0;
        while (n < 1000 && guard < 5000) begin
            out_ready3 = ($urandom_range(0, 3) != 0);
            if (!in_valid3 && $urandom_range(0, 4) != 0) begin
                c3_cur    = $urandom;
                in_sh3    = mask3(c3_cur, $urandom, $urandom);
                in_valid3 = 1'b1;
            end
            @(negedge clk);
            took = in_valid3 && in_ready3;
            @(posedge clk);
            #1;
            if (took) begin
                n++;
                in_valid3 = 1'b0;
            end
            guard++;
        end
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        cyc(3);
        chk("rnd columns", n, 1000);
        chk("rnd q empty", q1.size(), 0);
        chk("u2 q empty", q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
